core_step_ctrl: RTL and testbench

Parametrised run/step controller for the MIPS core that replaces switch-muxed derived clocks with a single-clock enable.
- Selects one of NUM_RATES divider rates and issues a one-cycle `core_ce` pulse at that rate.
- Adds debounced single-step, a PC breakpoint and an executed-instruction counter.
- Sits between the board switches/buttons and the core; the core and screen run on `clk` and are qualified by `core_ce`.

---
 rtl/core_step_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_core_step_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/core_step_ctrl.sv
// Run/step controller: divided single-clock enable for the core, debounced single-step,
// PC breakpoint (present only when STEP_CTRL_BREAKPOINT_EN is defined) and instruction counter.
module core_step_ctrl #(
  parameter int                    NUM_RATES    = 4,
  parameter int                    SEL_W        = 2,
  parameter logic [NUM_RATES*32-1:0] DIV_LIST   = {32'd450000000, 32'd90000, 32'd90, 32'd1},
  parameter int                    DEBOUNCE_CYC = 1000000,
  parameter int                    PC_W         = 32,
  parameter int                    CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run_en,
  input  logic [SEL_W-1:0] rate_sel,
  input  logic             step_btn,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             core_ce,
  output logic             halted,
  output logic             at_bp,
  output logic [CNT_W-1:0] instr_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  state_t             state_r, next_state_s;
  logic               run_s1_r, run_sync_r;
  logic [SEL_W-1:0]   rate_s1_r, rate_sync_r, rate_prev_r;
  logic               step_s1_r, step_sync_r;
  logic [DB_W-1:0]    deb_cnt_r;
  logic               deb_level_r, deb_prev_r;
  logic [31:0]        div_cnt_r, div_s;
  logic               step_req_s, rate_chg_s, tick_s, bp_hit_s, ce_next_s;
  logic               core_ce_r, halted_r;
  logic [CNT_W-1:0]   instr_count_r;

  // Out-of-range selects clamp to the last entry; a zero divisor behaves as 1.
  function automatic logic [31:0] div_of(input logic [SEL_W-1:0] sel);
    int          idx;
    logic [31:0] d;
    idx = (int'(sel) >= NUM_RATES) ? (NUM_RATES - 1) : int'(sel);
    d   = DIV_LIST[32*idx +: 32];
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

  // Two-flop synchronisers for the board inputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_s1_r    <= 1'b0;
      run_sync_r  <= 1'b0;
      rate_s1_r   <= '0;
      rate_sync_r <= '0;
      rate_prev_r <= '0;
      step_s1_r   <= 1'b0;
      step_sync_r <= 1'b0;
    end else begin
      run_s1_r    <= run_en;
      run_sync_r  <= run_s1_r;
      rate_s1_r   <= rate_sel;
      rate_sync_r <= rate_s1_r;
      rate_prev_r <= rate_sync_r;
      step_s1_r   <= step_btn;
      step_sync_r <= step_s1_r;
    end
  end

  // Debounce: a new level must persist DEBOUNCE_CYC consecutive cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_cnt_r   <= '0;
      deb_level_r <= 1'b0;
      deb_prev_r  <= 1'b0;
    end else begin
      deb_prev_r <= deb_level_r;
      if (step_sync_r != deb_level_r) begin
        if (deb_cnt_r == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb_level_r <= step_sync_r;
          deb_cnt_r   <= '0;
        end else begin
          deb_cnt_r <= deb_cnt_r + DB_W'(1);
        end
      end else begin
        deb_cnt_r <= '0;
      end
    end
  end

  assign step_req_s = deb_level_r & ~deb_prev_r;
  assign div_s      = div_of(rate_sync_r);
  assign rate_chg_s = (rate_sync_r != rate_prev_r);
  // The change cycle itself never ticks, so a rate switch cannot emit a short period.
  assign tick_s     = (state_r == ST_RUN) && !rate_chg_s && (div_cnt_r == div_s - 32'd1);

`ifdef STEP_CTRL_BREAKPOINT_EN
  assign bp_hit_s = bp_en && (pc == bp_addr);
`else
  logic unused_bp_s;
  assign unused_bp_s = ^{bp_en, bp_addr, pc};
  assign bp_hit_s    = 1'b0;
`endif

  // Next-state and enable decode
  always_comb begin
    next_state_s = state_r;
    ce_next_s    = 1'b0;
    case (state_r)
      ST_HALT: begin
        if (step_req_s) ce_next_s = 1'b1;
        else            ce_next_s = 1'b0;
        if (run_sync_r) next_state_s = ST_RUN;
        else            next_state_s = ST_HALT;
      end
      ST_RUN: begin
        if (tick_s && bp_hit_s) begin
          ce_next_s    = 1'b0;
          next_state_s = run_sync_r ? ST_BREAK : ST_HALT;
        end else begin
          ce_next_s    = tick_s;
          next_state_s = run_sync_r ? ST_RUN : ST_HALT;
        end
      end
      ST_BREAK: begin
        if (!run_sync_r) begin
          ce_next_s    = 1'b0;
          next_state_s = ST_HALT;
        end else if (step_req_s) begin
          ce_next_s    = 1'b1;
          next_state_s = ST_RUN;
        end else begin
          ce_next_s    = 1'b0;
          next_state_s = ST_BREAK;
        end
      end
      default: begin
        ce_next_s    = 1'b0;
        next_state_s = ST_HALT;
      end
    endcase
  end

  // Rate divider, held at zero outside RUN and restarted on a rate change
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_r <= 32'd0;
    end else if ((state_r != ST_RUN) || (next_state_s != ST_RUN) || rate_chg_s ||
                 (div_cnt_r == div_s - 32'd1)) begin
      div_cnt_r <= 32'd0;
    end else begin
      div_cnt_r <= div_cnt_r + 32'd1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_HALT;
      core_ce_r     <= 1'b0;
      halted_r      <= 1'b1;
      instr_count_r <= '0;
    end else begin
      state_r   <= next_state_s;
      core_ce_r <= ce_next_s;
      halted_r  <= (next_state_s != ST_RUN);
      if (ce_next_s) instr_count_r <= instr_count_r + CNT_W'(1);
      else           instr_count_r <= instr_count_r;
    end
  end

`ifdef STEP_CTRL_BREAKPOINT_EN
  logic at_bp_r;

  // Breakpoint indicator follows the BREAK state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) at_bp_r <= 1'b0;
    else       at_bp_r <= (next_state_s == ST_BREAK);
  end

  assign at_bp = at_bp_r;
`else
  assign at_bp = 1'b0;
`endif

  assign core_ce     = core_ce_r;
  assign halted      = halted_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_core_step_ctrl.sv
// Directed self-checking bench for core_step_ctrl (DIV_LIST={1,4,10,20}, DEBOUNCE_CYC=8, CNT_W=4).
module tb_core_step_ctrl;

  logic        clk = 1'b0;
  logic        rstn, run_en, step_btn, bp_en;
  logic [1:0]  rate_sel;
  logic [31:0] bp_addr, pc;
  logic        core_ce, halted, at_bp;
  logic [3:0]  instr_count;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  core_step_ctrl #(
    .NUM_RATES   (4),
    .SEL_W       (2),
    .DIV_LIST    ({32'd20, 32'd10, 32'd4, 32'd1}),
    .DEBOUNCE_CYC(8),
    .PC_W        (32),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .run_en     (run_en),
    .rate_sel   (rate_sel),
    .step_btn   (step_btn),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .core_ce    (core_ce),
    .halted     (halted),
    .at_bp      (at_bp),
    .instr_count(instr_count)
  );

  // Core model: the pc advances to the next instruction as soon as an enable is issued.
  always @(negedge clk or negedge rstn) begin
    if (!rstn)        pc <= 32'd0;
    else if (core_ce) pc <= pc + 32'd4;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycles until the next enable pulse, or -1 when none arrives within max_cyc.
  task automatic wait_ce(input int max_cyc, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (core_ce) break;
      if (n >= max_cyc) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic count_ce(input int cyc, output int n);
    n = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (core_ce) n++;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    logic ok;
    rstn = 1'b0; run_en = 1'b0; rate_sel = 2'd0; step_btn = 1'b0;
    bp_en = 1'b0; bp_addr = 32'd0;
    repeat (3) @(negedge clk);

    // Reset values and idle halt
    check_val("rst_ce", 32'(core_ce), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd1);
    check_val("rst_at_bp", 32'(at_bp), 32'd0);
    check_val("rst_count", 32'(instr_count), 32'd0);
    rstn = 1'b1;
    count_ce(50, n);
    check_val("halt_no_ce", 32'(n), 32'd0);
    check_val("halt_halted", 32'(halted), 32'd1);
    check_val("halt_count", 32'(instr_count), 32'd0);

    // Rate 1 (DIV=4), then switch to rate 2 (DIV=10) just after a pulse
    rate_sel = 2'd1;
    run_en   = 1'b1;
    wait_ce(20, n);
    check_val("rate_first", 32'(n), 32'd7);
    for (int i = 0; i < 3; i++) begin
      wait_ce(10, n);
      check_val("rate_div4", 32'(n), 32'd4);
    end
    rate_sel = 2'd2;
    wait_ce(30, n);
    check_val("rate_switch", 32'(n), 32'd13);
    wait_ce(30, n);
    check_val("rate_div10", 32'(n), 32'd10);
    check_val("rate_count", 32'(instr_count), 32'd6);
    check_val("rate_running", 32'(halted), 32'd0);
    run_en = 1'b0;
    count_ce(8, n);
    check_val("stop_no_ce", 32'(n), 32'd0);
    check_val("stop_halted", 32'(halted), 32'd1);

    // Bouncing step button, then a clean press and release
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step_btn = ((i / 3) % 2 == 0);
      @(negedge clk);
      if (core_ce) n++;
    end
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_ce) n++;
    end
    check_val("step_one_ce", 32'(n), 32'd1);
    check_val("step_count", 32'(instr_count), 32'd1);
    check_val("step_halted", 32'(halted), 32'd1);
    step_btn = 1'b0;
    count_ce(30, n);
    check_val("release_no_ce", 32'(n), 32'd0);
    check_val("release_count", 32'(instr_count), 32'd1);

    // Breakpoint at 0x10 running at DIV=1
    rate_sel = 2'd0;
    bp_en    = 1'b1;
    bp_addr  = 32'h0000_0010;
    do_reset();
    run_en = 1'b1;
    count_ce(20, n);
    #1;
`ifdef STEP_CTRL_BREAKPOINT_EN
    check_val("bp_ce_before", 32'(n), 32'd4);
    check_val("bp_pc", pc, 32'h0000_0010);
    check_val("bp_at_bp", 32'(at_bp), 32'd1);
    check_val("bp_halted", 32'(halted), 32'd1);
    check_val("bp_count", 32'(instr_count), 32'd4);
    step_btn = 1'b1;
    wait_ce(30, n);
    check_val("bp_step_ce", 32'(n > 0), 32'd1);
    check_val("bp_resume_halted", 32'(halted), 32'd0);
    check_val("bp_resume_at_bp", 32'(at_bp), 32'd0);
    check_val("bp_step_count", 32'(instr_count), 32'd5);
    #1;
    check_val("bp_step_pc", pc, 32'h0000_0014);
`else
    check_val("nobp_ce", 32'(n), 32'd17);
    check_val("nobp_pc", pc, 32'h0000_0044);
    check_val("nobp_at_bp", 32'(at_bp), 32'd0);
    check_val("nobp_halted", 32'(halted), 32'd0);
    check_val("nobp_count", 32'(instr_count), 32'd1);
`endif
    run_en   = 1'b0;
    step_btn = 1'b0;
    bp_en    = 1'b0;

    // Counter wrap at DIV=1, then asynchronous reset while running
    do_reset();
    run_en = 1'b1;
    ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      wait_ce(8, n);
      if (n < 0) ok = 1'b0;
      if (k == 15) check_val("wrap_15", 32'(instr_count), 32'd15);
      if (k == 16) check_val("wrap_0", 32'(instr_count), 32'd0);
    end
    check_val("wrap_all_ce", 32'(ok), 32'd1);
    check_val("wrap_count", 32'(instr_count), 32'd4);
    #2;
    rstn = 1'b0;
    #1;
    check_val("arst_ce", 32'(core_ce), 32'd0);
    check_val("arst_count", 32'(instr_count), 32'd0);
    check_val("arst_halted", 32'(halted), 32'd1);
    @(negedge clk);
    run_en = 1'b0;
    rstn   = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
